// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU definitions: control codes, op-class encodings, arbiter FSM states
// and the {alu_op, func3, func7} -> alu_ctrl decode used by the arbiter and execute stage.
package alu_share_arbiter_pkg;

  localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;

  localparam logic [2:0] FUNC3_ADDSUB = 3'b000;
  localparam logic [2:0] FUNC3_OR     = 3'b110;
  localparam logic [2:0] FUNC3_AND    = 3'b111;

  typedef enum logic [1:0] {
    ALU_OP_ADD    = 2'b00,
    ALU_OP_BRANCH = 2'b01,
    ALU_OP_FUNC   = 2'b10,
    ALU_OP_SUB    = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [2:0] func3;
    logic       func7;
  } op_fields_t;

  function automatic logic [3:0] alu_decode(input logic [1:0] alu_op,
                                            input logic [2:0] func3,
                                            input logic       func7);
    logic [3:0] ctrl;
    ctrl = ALU_CTRL_ADD;
    case (alu_op)
      ALU_OP_ADD:    ctrl = ALU_CTRL_ADD;
      ALU_OP_BRANCH: ctrl = ALU_CTRL_SUB;
      ALU_OP_SUB:    ctrl = ALU_CTRL_SUB;
      ALU_OP_FUNC: begin
        case (func3)
          FUNC3_ADDSUB: ctrl = func7 ? ALU_CTRL_SUB : ALU_CTRL_ADD;
          FUNC3_OR:     ctrl = ALU_CTRL_OR;
          FUNC3_AND:    ctrl = ALU_CTRL_AND;
          default:      ctrl = ALU_CTRL_ADD;
        endcase
      end
      default: ctrl = ALU_CTRL_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters (execute, branch-compare)
// and the shared ALU arbiter.
interface alu_share_arbiter_if #(
  parameter int XLEN = 32
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req0_alu_op;
  logic [2:0]      req0_func3;
  logic            req0_func7;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic [1:0]      req1_alu_op;
  logic [2:0]      req1_func3;
  logic            req1_func7;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_zero;

  modport master (
    output req_valid, req0_alu_op, req0_func3, req0_func7, req0_a, req0_b,
           req1_alu_op, req1_func3, req1_func7, req1_a, req1_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  req_valid, req0_alu_op, req0_func3, req0_func7, req0_a, req0_b,
           req1_alu_op, req1_func3, req1_func7, req1_a, req1_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone valid wins outright, a tie goes to the
// port that was not granted last time.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);
  assign grant[0] = valid[0] & (~valid[1] | last);
  assign grant[1] = valid[1] & (~valid[0] | ~last);
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// branch-compare unit (port 1), one operation in flight at a time.
//
//   state    | meaning
//   ST_IDLE  | offer req_ready to the round-robin winner, latch op on handshake
//   ST_ISSUE | drive ALU from latched op, capture result/zero at end of cycle
//   ST_RESP  | hold rsp_valid[grant_id] with captured result until accepted
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  alu_share_arbiter_if.slave bus,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  state_e     state;
  state_e     state_next;
  logic [1:0] pick;
  logic       last_grant;
  logic       grant_id;
  logic       accept;
  logic       capture;
  op_fields_t op_q;

  rr_arb2 u_rr_arb2 (
    .valid (bus.req_valid),
    .last  (last_grant),
    .grant (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    accept        = 1'b0;
    capture       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!reset && (pick != 2'b00)) begin
          bus.req_ready = pick;
          accept        = 1'b1;
          state_next    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        capture    = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid[grant_id] = 1'b1;
        if (bus.rsp_ready[grant_id]) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operands and op fields only change on a new accept, so the ALU inputs
  // stay quiet outside ISSUE and hold the last issued operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant     <= 1'b1;
      grant_id       <= 1'b0;
      op_q           <= '{alu_op: ALU_OP_ADD, func3: 3'b000, func7: 1'b0};
      alu_a          <= '0;
      alu_b          <= '0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        grant_id   <= pick[1];
        last_grant <= pick[1];
        if (pick[1]) begin
          op_q  <= '{alu_op: bus.req1_alu_op, func3: bus.req1_func3, func7: bus.req1_func7};
          alu_a <= bus.req1_a;
          alu_b <= bus.req1_b;
        end else begin
          op_q  <= '{alu_op: bus.req0_alu_op, func3: bus.req0_func3, func7: bus.req0_func7};
          alu_a <= bus.req0_a;
          alu_b <= bus.req0_b;
        end
      end
      if (capture) begin
        bus.rsp_result <= alu_result;
        bus.rsp_zero   <= alu_zero;
      end
    end
  end

  assign alu_ctrl = alu_decode(op_q.alu_op, op_q.func3, op_q.func7);

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.rsp_valid));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: external ALU model, randomized
// requests, round-robin and result predicted from the arbitration/decode rules.
module tb_alu_share_arbiter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  int   total;
  int   passed;
  logic model_last;

  alu_share_arbiter_if #(.XLEN(XLEN)) bus ();

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  function automatic logic [3:0] exp_ctrl(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    if (op == 2'b00) return 4'b0010;
    if (op != 2'b10) return 4'b0110;
    if (f3 == 3'd6) return 4'b0001;
    if (f3 == 3'd7) return 4'b0000;
    if (f3 == 3'd0 && f7) return 4'b0110;
    return 4'b0010;
  endfunction

  function automatic logic [XLEN-1:0] exp_res(input logic [1:0] op, input logic [2:0] f3,
                                              input logic f7, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    if (op == 2'b00) return a + b;
    if (op != 2'b10) return a - b;
    if (f3 == 3'd6) return a | b;
    if (f3 == 3'd7) return a & b;
    if (f3 == 3'd0 && f7) return a - b;
    return a + b;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic [1:0] op, input logic [2:0] f3, input logic f7,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (p == 0) begin
      bus.req0_alu_op = op; bus.req0_func3 = f3; bus.req0_func7 = f7; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_alu_op = op; bus.req1_func3 = f3; bus.req1_func7 = f7; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic rand_port(input int p);
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    a = $urandom;
    b = ($urandom_range(3) == 0) ? a : $urandom;
    set_port(p, 2'($urandom_range(3)), 3'($urandom_range(7)), 1'($urandom_range(1)), a, b);
  endtask

  // Runs one operation from IDLE (at a negedge) through its response handshake.
  task automatic run_txn(input bit hold_valid, input int rsp_wait);
    int              k;
    int              exp_id;
    logic [1:0]      exp_oh;
    logic [1:0]      op;
    logic [2:0]      f3;
    logic            f7;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] r;
    k = 0;
    #1;
    while (bus.req_ready == 2'b00 && k < 20) begin
      step(); #1; k++;
    end
    total++;
    if (bus.req_ready == 2'b00) begin
      $display("FAIL accept_timeout: req_ready=%b valid=%b after %0d cycles", bus.req_ready, bus.req_valid, k);
      return;
    end else passed++;
    exp_id = (bus.req_valid == 2'b11) ? (model_last ? 0 : 1) : (bus.req_valid[1] ? 1 : 0);
    exp_oh = (exp_id == 1) ? 2'b10 : 2'b01;
    total++;
    if (bus.req_ready !== exp_oh) $display("FAIL grant: req_ready=%b expected %b", bus.req_ready, exp_oh);
    else passed++;
    if (exp_id == 0) begin
      op = bus.req0_alu_op; f3 = bus.req0_func3; f7 = bus.req0_func7; a = bus.req0_a; b = bus.req0_b;
    end else begin
      op = bus.req1_alu_op; f3 = bus.req1_func3; f7 = bus.req1_func7; a = bus.req1_a; b = bus.req1_b;
    end
    model_last = exp_id[0];
    r = exp_res(op, f3, f7, a, b);

    @(negedge clk);
    total++;
    if (alu_ctrl !== exp_ctrl(op, f3, f7))
      $display("FAIL issue_ctrl: alu_ctrl=%b expected %b (op=%b f3=%b f7=%b)", alu_ctrl, exp_ctrl(op, f3, f7), op, f3, f7);
    else passed++;
    total++;
    if (alu_a !== a || alu_b !== b)
      $display("FAIL issue_operands: a=%h b=%h expected a=%h b=%h", alu_a, alu_b, a, b);
    else passed++;
    total++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00)
      $display("FAIL issue_quiet: req_ready=%b rsp_valid=%b expected 00/00", bus.req_ready, bus.rsp_valid);
    else passed++;

    if (!hold_valid) bus.req_valid[exp_id] = 1'b0;
    rand_port(exp_id);
    bus.rsp_ready = (rsp_wait > 0) ? ~exp_oh : 2'b11;

    k = 0;
    do begin
      step(); k++;
    end while (bus.rsp_valid == 2'b00 && k < 20);
    total++;
    if (k != 1) $display("FAIL latency: response after %0d edges from handshake, expected 2", k + 1);
    else passed++;
    total++;
    if (bus.rsp_valid !== exp_oh || bus.rsp_result !== r || bus.rsp_zero !== (r == '0))
      $display("FAIL response: valid=%b result=%h zero=%b expected %b %h %b",
               bus.rsp_valid, bus.rsp_result, bus.rsp_zero, exp_oh, r, (r == '0));
    else passed++;

    for (int i = 0; i < rsp_wait; i++) begin
      step();
      total++;
      if (bus.rsp_valid !== exp_oh || bus.rsp_result !== r || bus.req_ready !== 2'b00)
        $display("FAIL backpressure_hold: cycle %0d valid=%b result=%h req_ready=%b expected %b %h 00",
                 i, bus.rsp_valid, bus.rsp_result, bus.req_ready, exp_oh, r);
      else passed++;
    end

    bus.rsp_ready = 2'b11;
    step();
    total++;
    if (bus.rsp_valid !== 2'b00) $display("FAIL rsp_release: rsp_valid=%b expected 00", bus.rsp_valid);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    rand_port(0);
    rand_port(1);
    step();
    step();
    #1;
    total++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00)
      $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b expected 00/00", bus.req_ready, bus.rsp_valid);
    else passed++;
    total++;
    if (bus.rsp_result !== '0 || bus.rsp_zero !== 1'b0)
      $display("FAIL reset_rsp: result=%h zero=%b expected 0/0", bus.rsp_result, bus.rsp_zero);
    else passed++;
    total++;
    if (alu_ctrl !== 4'b0010 || alu_a !== '0 || alu_b !== '0)
      $display("FAIL reset_alu: ctrl=%b a=%h b=%h expected 0010/0/0", alu_ctrl, alu_a, alu_b);
    else passed++;
    bus.req_valid = 2'b00;
    reset = 1'b0;
    model_last = 1'b1;
    step();
  endtask

  task automatic test_single_op();
    set_port(0, 2'b10, 3'b000, 1'b1, 32'd9, 32'd4);
    bus.req_valid = 2'b01;
    run_txn(1'b0, 0);
  endtask

  task automatic test_contention();
    rand_port(0);
    set_port(1, 2'b01, 3'b000, 1'b0, 32'd7, 32'd7);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 8; i++) run_txn(1'b1, 0);
    bus.req_valid = 2'b00;
    step();
  endtask

  task automatic test_decode_sweep();
    for (int op = 0; op < 4; op++)
      for (int f3 = 0; f3 < 8; f3++)
        for (int f7 = 0; f7 < 2; f7++) begin
          set_port(0, 2'(op), 3'(f3), 1'(f7), $urandom, $urandom);
          bus.req_valid = 2'b01;
          run_txn(1'b0, 0);
        end
  endtask

  task automatic test_backpressure();
    rand_port(0);
    rand_port(1);
    bus.req_valid = 2'b11;
    run_txn(1'b0, 5);
    run_txn(1'b0, 0);
    bus.req_valid = 2'b00;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      if (bus.req_valid == 2'b00) bus.req_valid = 2'($urandom_range(1, 3));
      if ($urandom_range(1) == 1) rand_port(0);
      if ($urandom_range(1) == 1) rand_port(1);
      run_txn(1'($urandom_range(1)), $urandom_range(2));
    end
    bus.req_valid = 2'b00;
    step();
  endtask

  task automatic test_reset_mid_op();
    set_port(0, 2'b00, 3'b000, 1'b0, 32'd9, 32'd4);
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    reset = 1'b1;
    step();
    #1;
    total++;
    if (bus.rsp_valid !== 2'b00 || bus.rsp_result !== '0 || bus.rsp_zero !== 1'b0)
      $display("FAIL midop_reset_rsp: valid=%b result=%h zero=%b expected 00/0/0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_zero);
    else passed++;
    total++;
    if (alu_ctrl !== 4'b0010 || alu_a !== '0 || alu_b !== '0 || bus.req_ready !== 2'b00)
      $display("FAIL midop_reset_alu: ctrl=%b a=%h b=%h req_ready=%b expected 0010/0/0/00",
               alu_ctrl, alu_a, alu_b, bus.req_ready);
    else passed++;
    reset = 1'b0;
    model_last = 1'b1;
    step();
    total++;
    if (bus.rsp_valid !== 2'b00) $display("FAIL midop_no_pulse: rsp_valid=%b expected 00", bus.rsp_valid);
    else passed++;
    rand_port(0);
    rand_port(1);
    bus.req_valid = 2'b11;
    #1;
    total++;
    if (bus.req_ready !== 2'b01) $display("FAIL midop_first_tie: req_ready=%b expected 01", bus.req_ready);
    else passed++;
    run_txn(1'b0, 0);
    bus.req_valid = 2'b00;
    step();
  endtask

  initial begin
    total = 0;
    passed = 0;
    model_last = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_op();
    test_contention();
    test_decode_sweep();
    test_backpressure();
    test_random();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end
endmodule
